// File: rtl/reg_bank.sv
// 32-entry register bank: one-hot write port, two registered read ports,
// sticky multi-hot write detection and optional same-cycle write forwarding.
module reg_bank #(
  parameter int DATA_W   = 32,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       we_onehot,
  input  logic [DATA_W-1:0] w_data,
  input  logic              rd_en,
  input  logic [4:0]        ra_addr,
  input  logic [4:0]        rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  output logic              rd_valid,
  output logic              we_err
);

  logic [DATA_W-1:0] regs_q [32];
  logic [31:0]       entry_we;
  logic              we_legal;
  logic              we_multi;

  logic [DATA_W-1:0] ra_data_q, ra_data_d;
  logic [DATA_W-1:0] rb_data_q, rb_data_d;
  logic              rd_valid_q;
  logic              we_err_q, we_err_d;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  assign we_legal = (we_onehot != 32'd0) && ((we_onehot & (we_onehot - 32'd1)) == 32'd0);
  assign we_multi = (we_onehot != 32'd0) && !we_legal;

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_entry
      localparam bit TIED = ZERO_REG && (gi == 0);
      assign entry_we[gi] = we_legal & we_onehot[gi] & ~TIED;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          regs_q[gi] <= '0;
        end else if (entry_we[gi]) begin
          regs_q[gi] <= w_data;
        end
      end
    end
  endgenerate

  // entry_we already excludes suppressed writes, so it doubles as the bypass hit.
  always_comb begin
    ra_data_d = ra_data_q;
    rb_data_d = rb_data_q;
    we_err_d  = we_err_q | we_multi;
    if (rd_en) begin
      ra_data_d = (BYPASS && entry_we[ra_addr]) ? w_data : regs_q[ra_addr];
      rb_data_d = (BYPASS && entry_we[rb_addr]) ? w_data : regs_q[rb_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra_data_q  <= '0;
      rb_data_q  <= '0;
      rd_valid_q <= 1'b0;
      we_err_q   <= 1'b0;
    end else begin
      ra_data_q  <= ra_data_d;
      rb_data_q  <= rb_data_d;
      rd_valid_q <= rd_en;
      we_err_q   <= we_err_d;
    end
  end

  assign ra_data  = ra_data_q;
  assign rb_data  = rb_data_q;
  assign rd_valid = rd_valid_q;
  assign we_err   = we_err_q;

endmodule

// File: tb/tb_reg_bank.sv
// Bench for reg_bank: instance 0 uses ZERO_REG=1/BYPASS=1, instance 1 uses
// ZERO_REG=0/BYPASS=0; both are compared against an array-based reference model.
module tb_reg_bank;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   we_onehot = '0;
  logic [W-1:0]  w_data = '0;
  logic          rd_en = 1'b0;
  logic [4:0]    ra_addr = '0;
  logic [4:0]    rb_addr = '0;
  logic [W-1:0]  ra_data [2];
  logic [W-1:0]  rb_data [2];
  logic          rd_valid [2];
  logic          we_err [2];

  int errors = 0;
  int checks = 0;

  // Reference model state; index 0 = zero-reg+bypass instance, 1 = plain instance.
  logic [W-1:0]  m_mem [2][32];
  logic [W-1:0]  e_ra [2];
  logic [W-1:0]  e_rb [2];
  logic          e_valid;
  logic          e_err [2];

  always #5 clk = ~clk;

  reg_bank #(.DATA_W(W), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .we_onehot(we_onehot), .w_data(w_data),
    .rd_en(rd_en), .ra_addr(ra_addr), .rb_addr(rb_addr),
    .ra_data(ra_data[0]), .rb_data(rb_data[0]),
    .rd_valid(rd_valid[0]), .we_err(we_err[0])
  );

  reg_bank #(.DATA_W(W), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .we_onehot(we_onehot), .w_data(w_data),
    .rd_en(rd_en), .ra_addr(ra_addr), .rb_addr(rb_addr),
    .ra_data(ra_data[1]), .rb_data(rb_data[1]),
    .rd_valid(rd_valid[1]), .we_err(we_err[1])
  );

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 32; i++) m_mem[k][i] = '0;
      e_ra[k]  = '0;
      e_rb[k]  = '0;
      e_err[k] = 1'b0;
    end
    e_valid = 1'b0;
  endtask

  // What a read of address a returns at an edge where idx is written (idx<0: no legal write).
  function automatic logic [W-1:0] model_read(int k, int a, int idx);
    if (k == 0 && a == 0) return '0;
    if (k == 0 && idx == a) return w_data;
    return m_mem[k][a];
  endfunction

  task automatic model_edge();
    int pc;
    int idx;
    pc  = $countones(we_onehot);
    idx = -1;
    if (pc == 1) begin
      for (int i = 0; i < 32; i++) if (we_onehot[i]) idx = i;
    end
    for (int k = 0; k < 2; k++) begin
      if (rd_en) begin
        e_ra[k] = model_read(k, int'(ra_addr), idx);
        e_rb[k] = model_read(k, int'(rb_addr), idx);
      end
      if (pc >= 2) e_err[k] = 1'b1;
      if (idx >= 0 && !(k == 0 && idx == 0)) m_mem[k][idx] = w_data;
    end
    e_valid = rd_en;
  endtask

  task automatic cycle(input logic [31:0] we, input logic [W-1:0] wd,
                       input logic re, input logic [4:0] a, input logic [4:0] b);
    @(negedge clk);
    we_onehot = we;
    w_data    = wd;
    rd_en     = re;
    ra_addr   = a;
    rb_addr   = b;
    @(posedge clk);
    model_edge();
    #1;
    $display("txn t=%0t we=%h wd=%h rd=%0d a=%0d b=%0d | ra=%h/%h rb=%h/%h v=%0d/%0d err=%0d/%0d",
             $time, we, wd, re, a, b, ra_data[0], ra_data[1], rb_data[0], rb_data[1],
             rd_valid[0], rd_valid[1], we_err[0], we_err[1]);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #12;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (ra_data[k] !== '0 || rd_valid[k] !== 1'b0 || we_err[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state[%0d]: got ra=%h v=%b err=%b required 0/0/0",
                 k, ra_data[k], rd_valid[k], we_err[k]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycle('0, '0, 1'b1, 5'd5, 5'd31);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (rd_valid[k] !== 1'b1 || ra_data[k] !== '0 || rb_data[k] !== '0 || we_err[k] !== 1'b0) begin
        errors++;
        $display("FAIL first_read[%0d]: got v=%b ra=%h rb=%h err=%b required 1/0/0/0",
                 k, rd_valid[k], ra_data[k], rb_data[k], we_err[k]);
      end
    end
  endtask

  task automatic test_write_read();
    cycle(32'h0000_0020, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (rd_valid[k] !== 1'b0) begin
        errors++;
        $display("FAIL idle_valid[%0d]: got %b required 0", k, rd_valid[k]);
      end
    end
    cycle('0, '0, 1'b1, 5'd5, 5'd5);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (ra_data[k] !== 32'hDEAD_BEEF || rb_data[k] !== 32'hDEAD_BEEF) begin
        errors++;
        $display("FAIL write_read[%0d]: got ra=%h rb=%h required deadbeef", k, ra_data[k], rb_data[k]);
      end
    end
  endtask

  task automatic test_bypass();
    cycle(32'h8000_0000, 32'hCAFE_0031, 1'b0, 5'd0, 5'd0);
    cycle(32'h8000_0000, 32'h1234_5678, 1'b1, 5'd31, 5'd5);
    checks++;
    if (ra_data[0] !== 32'h1234_5678) begin
      errors++;
      $display("FAIL bypass_on: got %h required 12345678", ra_data[0]);
    end
    checks++;
    if (ra_data[1] !== 32'hCAFE_0031) begin
      errors++;
      $display("FAIL bypass_off: got %h required cafe0031", ra_data[1]);
    end
    cycle('0, '0, 1'b1, 5'd31, 5'd31);
    checks++;
    if (ra_data[1] !== 32'h1234_5678 || rb_data[0] !== 32'h1234_5678) begin
      errors++;
      $display("FAIL after_bypass: got %h/%h required 12345678", ra_data[1], rb_data[0]);
    end
  endtask

  task automatic test_zero_reg();
    cycle(32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 5'd0, 5'd0);
    checks++;
    if (ra_data[0] !== '0) begin
      errors++;
      $display("FAIL zero_same_edge: got %h required 0", ra_data[0]);
    end
    cycle('0, '0, 1'b1, 5'd0, 5'd0);
    checks++;
    if (ra_data[0] !== '0 || rb_data[0] !== '0 || we_err[0] !== 1'b0) begin
      errors++;
      $display("FAIL zero_reg: got ra=%h rb=%h err=%b required 0/0/0", ra_data[0], rb_data[0], we_err[0]);
    end
    checks++;
    if (ra_data[1] !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL plain_reg0: got %h required ffffffff", ra_data[1]);
    end
  endtask

  task automatic test_multi_hot();
    cycle(32'h0000_0002, 32'h0000_0011, 1'b0, 5'd0, 5'd0);
    cycle(32'h0000_0003, 32'hAAAA_AAAA, 1'b1, 5'd1, 5'd0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (ra_data[k] !== 32'h0000_0011 || we_err[k] !== 1'b1) begin
        errors++;
        $display("FAIL multi_hot[%0d]: got ra=%h err=%b required 00000011/1", k, ra_data[k], we_err[k]);
      end
    end
    cycle('0, '0, 1'b1, 5'd1, 5'd0);
    checks++;
    if (ra_data[0] !== 32'h11 || rb_data[0] !== '0 || ra_data[1] !== 32'h11 || rb_data[1] !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL multi_unchanged: got %h %h %h %h required 11 0 11 ffffffff",
               ra_data[0], rb_data[0], ra_data[1], rb_data[1]);
    end
    for (int c = 0; c < 10; c++) cycle('0, '0, 1'b0, 5'd0, 5'd0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (we_err[k] !== 1'b1) begin
        errors++;
        $display("FAIL err_sticky[%0d]: got %b required 1", k, we_err[k]);
      end
    end
    #1;
    rst_n = 1'b0;
    model_reset();
    #2;
    checks++;
    if (we_err[0] !== 1'b0 || we_err[1] !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: got %b/%b required 0/0", we_err[0], we_err[1]);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_async_reset();
    cycle(32'h0000_0080, 32'h0000_0055, 1'b0, 5'd0, 5'd0);
    cycle('0, '0, 1'b1, 5'd7, 5'd7);
    checks++;
    if (ra_data[0] !== 32'h55 || ra_data[1] !== 32'h55) begin
      errors++;
      $display("FAIL pre_reset_read: got %h/%h required 55", ra_data[0], ra_data[1]);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (ra_data[k] !== '0 || rd_valid[k] !== 1'b0) begin
        errors++;
        $display("FAIL async_clear[%0d]: got ra=%h v=%b required 0/0", k, ra_data[k], rd_valid[k]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycle('0, '0, 1'b1, 5'd7, 5'd7);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (ra_data[k] !== '0 || rd_valid[k] !== 1'b1) begin
        errors++;
        $display("FAIL post_reset_read[%0d]: got ra=%h v=%b required 0/1", k, ra_data[k], rd_valid[k]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] we;
    int sel;
    for (int n = 0; n < 300; n++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 65)      we = 32'd1 << $urandom_range(0, 31);
      else if (sel < 95) we = '0;
      else               we = (32'd1 << $urandom_range(0, 15)) | (32'd1 << $urandom_range(16, 31));
      cycle(we, $urandom, 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (ra_data[k] !== e_ra[k] || rb_data[k] !== e_rb[k] ||
            rd_valid[k] !== e_valid || we_err[k] !== e_err[k]) begin
          errors++;
          $display("FAIL random[%0d] n=%0d: got ra=%h rb=%h v=%b err=%b required ra=%h rb=%h v=%b err=%b",
                   k, n, ra_data[k], rb_data[k], rd_valid[k], we_err[k],
                   e_ra[k], e_rb[k], e_valid, e_err[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_multi_hot();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
